// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM channel arbiter: bus widths, FSM states
// and the read data returned when the watchdog forces a completion.
package sdram_pkg;

  localparam int SDRAM_DATA_BITS = 16;
  localparam int SDRAM_MASK_BITS = 2;
  localparam int ARB_WD_BITS     = 6;

  localparam logic [SDRAM_DATA_BITS-1:0] ARB_TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESPOND
  } arb_state_t;

endpackage

// File: rtl/sdram_bus.sv
// One SDRAM controller channel: pulse req/ack handshake with address, write
// data, mask and read data. The controller side issues, the memory side answers.
interface sdram_bus
  import sdram_pkg::*;
#(
  parameter int ADDR_BITS = 22
);

  logic                       req;
  logic                       ack;
  logic [ADDR_BITS-1:0]       address;
  logic [SDRAM_DATA_BITS-1:0] data_write;
  logic [SDRAM_DATA_BITS-1:0] data_read;
  logic                       we;
  logic [SDRAM_MASK_BITS-1:0] wm;

  modport controller (
    output req, address, data_write, we, wm,
    input  ack, data_read
  );

  modport memory (
    input  req, address, data_write, we, wm,
    output ack, data_read
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set bit of valid at or after rr,
// wrapping around, plus a flag telling whether any bit is set.
module rr_pick #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         valid,
  input  logic [$clog2(NUM_PORTS)-1:0] rr,
  output logic                         any,
  output logic [$clog2(NUM_PORTS)-1:0] sel
);

  localparam int RR_BITS = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] rotated;

  // Bit k of rotated is port (rr + k) mod NUM_PORTS; lowest k wins.
  always_comb begin
    rotated = NUM_PORTS'({valid, valid} >> rr);
    any     = |rotated;
    sel     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        sel = RR_BITS'((int'(rr) + k) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller channel between NUM_PORTS
// pulse-request hosts, one downstream transaction at a time, with an ack watchdog.
module sdram_rr_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_BITS = 22,
  parameter int TIMEOUT   = 63
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdram_bus.memory             host [NUM_PORTS],
  sdram_bus.controller         mem,
  output logic [NUM_PORTS-1:0] overflow,
  output logic                 timeout_err
);

  localparam int RR_BITS = $clog2(NUM_PORTS);
  localparam logic [ARB_WD_BITS-1:0] WD_LIMIT = ARB_WD_BITS'(TIMEOUT);

  arb_state_t state_reg, state_next;

  logic [NUM_PORTS-1:0]       valid_vec;
  logic [ADDR_BITS-1:0]       slot_addr  [NUM_PORTS];
  logic [SDRAM_DATA_BITS-1:0] slot_wdata [NUM_PORTS];
  logic [SDRAM_MASK_BITS-1:0] slot_wm    [NUM_PORTS];
  logic [NUM_PORTS-1:0]       slot_we;

  logic [RR_BITS-1:0]     rr_reg, grant_reg, pick_sel;
  logic                   pick_any;
  logic [ARB_WD_BITS-1:0] wd_reg;
  logic                   timeout_err_reg;

  logic                       mem_req_reg, mem_we_reg;
  logic [ADDR_BITS-1:0]       mem_addr_reg;
  logic [SDRAM_DATA_BITS-1:0] mem_wdata_reg;
  logic [SDRAM_MASK_BITS-1:0] mem_wm_reg;

  logic wait_done, wd_expired, respond;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .valid (valid_vec),
    .rr    (rr_reg),
    .any   (pick_any),
    .sel   (pick_sel)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A real ack takes precedence over the watchdog when both land together.
  always_comb begin
    state_next = state_reg;
    wait_done  = (state_reg == ARB_WAIT) && (mem.ack || (wd_reg == WD_LIMIT));
    wd_expired = (state_reg == ARB_WAIT) && !mem.ack && (wd_reg == WD_LIMIT);
    respond    = (state_reg == ARB_RESPOND);
    case (state_reg)
      ARB_IDLE:    if (pick_any) state_next = ARB_ISSUE;
      ARB_ISSUE:   state_next = ARB_WAIT;
      ARB_WAIT:    if (wait_done) state_next = ARB_RESPOND;
      ARB_RESPOND: state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  // Issue register: loaded on the IDLE->ISSUE edge so mem.req is high during ISSUE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wm_reg    <= '0;
      grant_reg     <= '0;
    end else begin
      mem_req_reg <= 1'b0;
      if (state_reg == ARB_IDLE && pick_any) begin
        mem_req_reg   <= 1'b1;
        grant_reg     <= pick_sel;
        mem_addr_reg  <= slot_addr[pick_sel];
        mem_wdata_reg <= slot_wdata[pick_sel];
        mem_we_reg    <= slot_we[pick_sel];
        mem_wm_reg    <= slot_wm[pick_sel];
      end
    end
  end

  // The watchdog holds the number of WAIT cycles including the current one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_reg          <= '0;
      rr_reg          <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == ARB_ISSUE) begin
        wd_reg <= ARB_WD_BITS'(1);
      end else if (state_reg == ARB_WAIT) begin
        wd_reg <= wd_reg + ARB_WD_BITS'(1);
      end
      if (wd_expired) begin
        timeout_err_reg <= 1'b1;
      end
      if (respond) begin
        rr_reg <= (grant_reg == RR_BITS'(NUM_PORTS - 1)) ? '0 : grant_reg + RR_BITS'(1);
      end
    end
  end

  assign mem.req        = mem_req_reg;
  assign mem.address    = mem_addr_reg;
  assign mem.data_write = mem_wdata_reg;
  assign mem.we         = mem_we_reg;
  assign mem.wm         = mem_wm_reg;
  assign timeout_err    = timeout_err_reg;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic                       valid_reg, overflow_reg, we_reg, ack_reg;
    logic [ADDR_BITS-1:0]       addr_reg;
    logic [SDRAM_DATA_BITS-1:0] wdata_reg, rdata_reg;
    logic [SDRAM_MASK_BITS-1:0] wm_reg;
    logic                       grant_match, port_clear;

    assign grant_match = (grant_reg == RR_BITS'(gi));
    assign port_clear  = respond && grant_match;

    // A request arriving as the slot retires is captured, not flagged.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        valid_reg    <= 1'b0;
        overflow_reg <= 1'b0;
      end else if (host[gi].req) begin
        if (valid_reg && !port_clear) begin
          overflow_reg <= 1'b1;
        end else begin
          valid_reg <= 1'b1;
          addr_reg  <= host[gi].address;
          wdata_reg <= host[gi].data_write;
          we_reg    <= host[gi].we;
          wm_reg    <= host[gi].wm;
        end
      end else if (port_clear) begin
        valid_reg <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        ack_reg   <= 1'b0;
        rdata_reg <= '0;
      end else begin
        ack_reg <= wait_done && grant_match;
        if (wait_done && grant_match) begin
          if (mem.ack) begin
            if (!mem_we_reg) begin
              rdata_reg <= mem.data_read;
            end
          end else begin
            rdata_reg <= ARB_TIMEOUT_DATA;
          end
        end
      end
    end

    assign valid_vec[gi]     = valid_reg;
    assign slot_addr[gi]     = addr_reg;
    assign slot_wdata[gi]    = wdata_reg;
    assign slot_we[gi]       = we_reg;
    assign slot_wm[gi]       = wm_reg;
    assign overflow[gi]      = overflow_reg;
    assign host[gi].ack       = ack_reg;
    assign host[gi].data_read = rdata_reg;
  end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter: a latency-programmable controller model,
// a negedge monitor logging every host ack, and hand-computed expectations.
module tb_sdram_rr_arbiter;
  import sdram_pkg::*;

  localparam int NP = 4;
  localparam int AB = 22;
  localparam int TO = 63;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdram_bus #(.ADDR_BITS(AB)) host_if [NP] ();
  sdram_bus #(.ADDR_BITS(AB)) mem_if ();

  logic [NP-1:0] overflow;
  logic          timeout_err;

  logic [NP-1:0] h_req, h_ack, h_we;
  logic [AB-1:0] h_addr  [NP];
  logic [15:0]   h_wdata [NP];
  logic [15:0]   h_rdata [NP];
  logic [1:0]    h_wm    [NP];
  logic          m_ack;
  logic [15:0]   m_rdata;

  for (genvar gi = 0; gi < NP; gi++) begin : g_host
    assign host_if[gi].req        = h_req[gi];
    assign host_if[gi].address    = h_addr[gi];
    assign host_if[gi].data_write = h_wdata[gi];
    assign host_if[gi].we         = h_we[gi];
    assign host_if[gi].wm         = h_wm[gi];
    assign h_ack[gi]              = host_if[gi].ack;
    assign h_rdata[gi]            = host_if[gi].data_read;
  end
  assign mem_if.ack       = m_ack;
  assign mem_if.data_read = m_rdata;

  sdram_rr_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .host        (host_if),
    .mem         (mem_if),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          ack_cnt  [NP] = '{default: 0};
  int          ack_cyc  [NP] = '{default: 0};
  logic [15:0] ack_data [NP] = '{default: 16'h0};
  int          mreq_cnt = 0;
  int          mreq_cyc = 0;
  logic [AB-1:0] mreq_addr = '0;
  logic [15:0]   mreq_wdata = '0;
  logic          mreq_we = 1'b0;
  logic [1:0]    mreq_wm = 2'b00;

  int          model_lat = 5;
  logic [15:0] model_data = 16'h0;
  bit          model_noack = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Controller model: ack exactly model_lat cycles after the mem.req cycle.
  initial begin
    int cnt;
    cnt = 0;
    m_ack = 1'b0;
    m_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      m_ack = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !model_noack) begin
          m_ack = 1'b1;
          m_rdata = model_data;
        end
      end
      if (mem_if.req === 1'b1) cnt = model_lat;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_if.req === 1'b1) begin
      mreq_cnt++;
      mreq_cyc   = cyc;
      mreq_addr  = mem_if.address;
      mreq_wdata = mem_if.data_write;
      mreq_we    = mem_if.we;
      mreq_wm    = mem_if.wm;
    end
    for (int i = 0; i < NP; i++) begin
      if (h_ack[i] === 1'b1) begin
        ack_cnt[i]++;
        ack_cyc[i]  = cyc;
        ack_data[i] = h_rdata[i];
        $display("txn port=%0d addr=%h we=%0d data_read=%h cycle=%0d",
                 i, mreq_addr, mreq_we, h_rdata[i], cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AB-1:0] a, input logic [15:0] d,
                          input logic we, input logic [1:0] wm);
    h_addr[p]  = a;
    h_wdata[p] = d;
    h_we[p]    = we;
    h_wm[p]    = wm;
  endtask

  task automatic fire(input logic [NP-1:0] mask);
    h_req = mask;
    tick();
    h_req = '0;
  endtask

  task automatic wait_ack(input int p, input int target, input int budget);
    for (int i = 0; i < budget && ack_cnt[p] < target; i++) tick();
    check($sformatf("ack_wait_p%0d", p), ack_cnt[p], target);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_req"},   mem_if.req, 0);
    check({pfx, "_mem_addr"},  mem_if.address, 0);
    check({pfx, "_mem_wdata"}, mem_if.data_write, 0);
    check({pfx, "_mem_we_wm"}, {mem_if.we, mem_if.wm}, 0);
    check({pfx, "_host_ack"},  h_ack, 0);
    check({pfx, "_rdata01"},   {h_rdata[0], h_rdata[1]}, 0);
    check({pfx, "_rdata23"},   {h_rdata[2], h_rdata[3]}, 0);
    check({pfx, "_overflow"},  overflow, 0);
    check({pfx, "_timeout"},   timeout_err, 0);
  endtask

  initial begin
    int c0, b, k;
    logic [NP-1:0] pend;
    h_req = '0;
    h_we  = '0;
    for (int i = 0; i < NP; i++) set_port(i, '0, 16'h0, 1'b0, 2'b00);

    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    reset_n = 1'b1;
    tick();

    // Single read, L=5: mem.req one cycle after the capture edge, ack 7 after.
    model_lat = 5; model_data = 16'hBEEF;
    set_port(1, 22'h012345, 16'h0, 1'b0, 2'b00);
    b = mreq_cnt;
    fire(4'b0010);
    c0 = cyc;
    wait_ack(1, 1, 30);
    check("rd_mreq_cycle", mreq_cyc - c0, 1);
    check("rd_mreq_count", mreq_cnt - b, 1);
    check("rd_mreq_addr",  mreq_addr, 22'h012345);
    check("rd_mreq_we",    mreq_we, 0);
    check("rd_ack_cycle",  ack_cyc[1] - c0, 7);
    check("rd_ack_data",   ack_data[1], 16'hBEEF);
    check("rd_other_acks", ack_cnt[0] + ack_cnt[2] + ack_cnt[3], 0);

    // Write masking: port 2 reads 5A5A first, then a write must not disturb it.
    model_lat = 3; model_data = 16'h5A5A;
    set_port(2, 22'h100000, 16'h0, 1'b0, 2'b00);
    fire(4'b0100);
    wait_ack(2, 1, 30);
    check("wr_pre_read", ack_data[2], 16'h5A5A);
    model_data = 16'h1234;
    set_port(2, 22'h200321, 16'h00A5, 1'b1, 2'b10);
    fire(4'b0100);
    wait_ack(2, 2, 30);
    check("wr_mem_we",    mreq_we, 1);
    check("wr_mem_wm",    mreq_wm, 2'b10);
    check("wr_mem_wdata", mreq_wdata, 16'h00A5);
    check("wr_mem_addr",  mreq_addr, 22'h200321);
    check("wr_rdata_held", h_rdata[2], 16'h5A5A);

    // Overflow: second req 2 cycles later while the slot is pending.
    model_lat = 8; model_data = 16'h0F0F;
    set_port(0, 22'h00ABCD, 16'h0, 1'b0, 2'b00);
    b = mreq_cnt;
    fire(4'b0001);
    tick();
    set_port(0, 22'h3FFFFF, 16'h0, 1'b0, 2'b00);
    fire(4'b0001);
    wait_ack(0, 1, 40);
    repeat (6) tick();
    check("ovf_mreq_count", mreq_cnt - b, 1);
    check("ovf_mreq_addr",  mreq_addr, 22'h00ABCD);
    check("ovf_ack_count",  ack_cnt[0], 1);
    check("ovf_flag",       overflow, 4'b0001);

    // Same-cycle capture: port 3 re-requests in its RESPOND cycle (L=4 -> c0+6).
    model_lat = 4; model_data = 16'hC0DE;
    set_port(3, 22'h2AAAAA, 16'h0, 1'b0, 2'b00);
    b = mreq_cnt;
    fire(4'b1000);
    c0 = cyc;
    repeat (6) tick();
    set_port(3, 22'h155555, 16'h0, 1'b0, 2'b00);
    fire(4'b1000);
    check("sc_first_ack_cycle", ack_cyc[3] - c0, 6);
    wait_ack(3, 2, 30);
    check("sc_mreq_count", mreq_cnt - b, 2);
    check("sc_mreq_addr",  mreq_addr, 22'h155555);
    check("sc_ack_data",   ack_data[3], 16'hC0DE);
    check("sc_overflow",   overflow, 4'b0001);

    // Watchdog: no ack for port 1; port 2 queued behind it is served next.
    model_noack = 1'b1; model_lat = 2; model_data = 16'h7777;
    set_port(1, 22'h0BAD00, 16'h0, 1'b0, 2'b00);
    set_port(2, 22'h0600D0, 16'h0, 1'b0, 2'b00);
    b = mreq_cnt;
    fire(4'b0110);
    wait_ack(1, 2, 100);
    check("wd_latency",   ack_cyc[1] - mreq_cyc, TO + 1);
    check("wd_data",      ack_data[1], 16'hFFFF);
    check("wd_addr",      mreq_addr, 22'h0BAD00);
    check("wd_err_flag",  timeout_err, 1);
    model_noack = 1'b0;
    wait_ack(2, 3, 30);
    check("wd_next_addr",  mreq_addr, 22'h0600D0);
    check("wd_next_data",  ack_data[2], 16'h7777);
    check("wd_mreq_count", mreq_cnt - b, 2);
    check("wd_err_sticky", timeout_err, 1);

    // Reset for one cycle mid-WAIT; the model's ack then arrives late.
    model_lat = 10; model_data = 16'hDEAD;
    set_port(0, 22'h0CAFE0, 16'h0, 1'b0, 2'b00);
    b = mreq_cnt;
    c0 = ack_cnt[0];
    fire(4'b0001);
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid");
    repeat (12) tick();
    check("mid_no_host_ack", ack_cnt[0] - c0, 0);
    check("mid_mreq_count",  mreq_cnt - b, 1);
    check("mid_late_ignored", h_rdata[0], 16'h0);

    // Fairness from rr=0: all four request, each re-requests after its ack.
    model_lat = 2; model_data = 16'h1111;
    for (int i = 0; i < NP; i++) set_port(i, AB'(i * 16), 16'h0, 1'b0, 2'b00);
    k = 0;
    h_req = 4'b1111;
    for (int t = 0; t < 300 && k < 12; t++) begin
      @(negedge clk);
      pend = '0;
      for (int i = 0; i < NP; i++) begin
        if (h_ack[i] === 1'b1) begin
          check($sformatf("fair_order_%0d", k), i, k % NP);
          k++;
          pend[i] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      h_req = pend;
    end
    h_req = '0;
    check("fair_count", k, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish within bound");
    $fatal(1);
  end

endmodule
